// File: rtl/obi_data_responder.sv
// Data-side OBI responder: word-addressed SRAM model with fixed response latency,
// an outstanding-transaction limit and LFSR-driven pseudo-random grant stalls.
module obi_data_responder #(
  parameter int unsigned MEM_ADDR_WIDTH  = 12,
  parameter int unsigned RESP_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        stall_en_i,
  output logic [3:0]  outstanding_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [31:0]               mem_q [DEPTH];
  logic [15:0]               lfsr_q, lfsr_d;
  logic [RESP_LATENCY-1:0]   vld_q;
  logic [31:0]               rdata_q [RESP_LATENCY];
  logic [3:0]                outstanding_q, outstanding_d;
  logic [31:0]               rd_cnt_q, rd_cnt_d;
  logic [31:0]               wr_cnt_q, wr_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic                      stall;
  logic                      accept;
  logic                      unused_addr;

  // Upper address bits alias onto the array; byte-offset bits are ignored.
  assign idx         = data_addr_i[MEM_ADDR_WIDTH+1:2];
  assign unused_addr = ^{data_addr_i[31:MEM_ADDR_WIDTH+2], data_addr_i[1:0]};

  assign stall         = stall_en_i && (lfsr_q[1:0] == 2'b00);
  assign data_rvalid_o = vld_q[RESP_LATENCY-1];
  assign data_rdata_o  = rdata_q[RESP_LATENCY-1];
  assign outstanding_o = outstanding_q;
  assign rd_cnt_o      = rd_cnt_q;
  assign wr_cnt_o      = wr_cnt_q;

  // A response retiring this cycle frees its slot for an immediate reuse.
  assign data_gnt_o = data_req_i && !stall &&
                      ((outstanding_q < 4'(MAX_OUTSTANDING)) || data_rvalid_o);
  assign accept     = data_req_i && data_gnt_o;

  always_comb begin
    lfsr_d        = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    outstanding_d = outstanding_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    case ({accept, data_rvalid_o})
      2'b10:   outstanding_d = outstanding_q + 4'(1);
      2'b01:   outstanding_d = outstanding_q - 4'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (accept && data_we_i)  wr_cnt_d = wr_cnt_q + 32'(1);
    if (accept && !data_we_i) rd_cnt_d = rd_cnt_q + 32'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q        <= LFSR_SEED;
      outstanding_q <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      outstanding_q <= outstanding_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  // Response pipeline; idle and write stages carry zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) rdata_q[i] <= '0;
    end else begin
      vld_q[0]   <= accept;
      rdata_q[0] <= (accept && !data_we_i) ? mem_q[idx] : 32'h0;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed bench for obi_data_responder: vector table plus multi-cycle sequences.
module tb_obi_data_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, stall_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid;
  logic [31:0] rdata, rd_cnt, wr_cnt;
  logic [3:0]  outst;

  logic        req2 = 1'b0;
  logic        gnt2, rvalid2;
  logic [31:0] rdata2, rd_cnt2, wr_cnt2;
  logic [3:0]  outst2;

  logic [15:0] mlfsr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_data_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .stall_en_i(stall_en),
    .outstanding_o(outst), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  obi_data_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req2), .data_gnt_o(gnt2),
    .data_addr_i(32'h0), .data_we_i(1'b0), .data_be_i(4'hF), .data_wdata_i(32'h0),
    .data_rvalid_o(rvalid2), .data_rdata_o(rdata2), .stall_en_i(1'b0),
    .outstanding_o(outst2), .rd_cnt_o(rd_cnt2), .wr_cnt_o(wr_cnt2)
  );

  // Reference stall LFSR: Fibonacci, taps 16,14,13,11, reset to the seed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mlfsr <= 16'hACE1;
    else        mlfsr <= {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Single transaction with no stalls: grant in the request cycle, response RL cycles later.
  task automatic txn(input vec_t v);
    @(posedge clk); #1;
    req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
    @(negedge clk);
    check("gnt_same_cycle", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= RL; k++) begin
      @(negedge clk);
      if (k < RL) check("rvalid_early", 32'(rvalid), 32'd0);
      else begin
        check("rvalid_at_latency", 32'(rvalid), 32'd1);
        check("rdata", rdata, v.exp);
      end
    end
  endtask

  logic [31:0] exp3 [16];
  logic [31:0] q5 [$];
  int n_wr, n_rd, peak, ri, first_rv, last_rv, viol, acc_m, acc_d, rv5, bad5, word;
  logic [31:0] rd_base;
  logic        exp_g;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0104, 4'hF, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0104, 4'h5, 32'hAABB_CCDD, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0104, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[5]  = '{1'b0, 32'h0000_4104, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[6]  = '{1'b1, 32'h0000_0104, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0107, 4'hF, 32'h0,         32'h11BB_33DD};
    vecs[8]  = '{1'b1, 32'h0000_0108, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0108, 4'hA, 32'h1234_5678, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0108, 4'hF, 32'h0,         32'h12FF_56FF};
    vecs[11] = '{1'b0, 32'hFFFF_C100, 4'hF, 32'h0,         32'hDEAD_BEEF};

    // Reset state
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_outstanding", 32'(outst), 32'd0);
    check("rst_rd_cnt", rd_cnt, 32'd0);
    check("rst_wr_cnt", wr_cnt, 32'd0);
    check("rst2_rvalid", 32'(rvalid2), 32'd0);
    check("rst2_rdata", rdata2, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of single transactions
    n_wr = 0; n_rd = 0;
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i]);
      if (vecs[i].we) n_wr++; else n_rd++;
      if (i == 1) begin
        check("wr_cnt_after_t1", wr_cnt, 32'd1);
        check("rd_cnt_after_t1", rd_cnt, 32'd1);
      end
    end
    check("wr_cnt_table", wr_cnt, 32'(n_wr));
    check("rd_cnt_table", rd_cnt, 32'(n_rd));

    // Back-to-back: 8 writes then 8 reads (first read hits the word written the cycle before)
    for (int i = 0; i < 16; i++)
      exp3[i] = (i < 8) ? 32'h0 : 32'hA000_0000 + 32'((i == 8) ? 7 : i - 9);
    peak = 0; ri = 0; first_rv = -1; last_rv = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk); #1;
          req = 1'b1; be = 4'hF;
          we = (i < 8);
          word = (i < 8) ? i : ((i == 8) ? 7 : i - 9);
          addr = 32'(word * 4);
          wdata = 32'hA000_0000 + 32'(i);
          @(negedge clk);
          check("b2b_gnt", 32'(gnt), 32'd1);
        end
        @(posedge clk); #1;
        req = 1'b0;
      end
      begin
        for (int c = 0; c < 25; c++) begin
          @(negedge clk);
          if (32'(outst) > peak) peak = 32'(outst);
          if (rvalid) begin
            if (first_rv < 0) first_rv = c;
            last_rv = c;
            if (ri < 16) check("b2b_rdata", rdata, exp3[ri]);
            ri++;
          end
        end
      end
    join
    check("b2b_resp_count", 32'(ri), 32'd16);
    check("b2b_resp_consecutive", 32'(last_rv - first_rv), 32'd15);
    check("b2b_peak_outstanding", 32'(peak), 32'd2);

    // MAX_OUTSTANDING=1, latency 3: accepts every third cycle
    viol = 0;
    @(posedge clk); #1;
    req2 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("mo1_gnt", 32'(gnt2), 32'((k % 3) == 0));
      if (outst2 > 4'd1) viol++;
    end
    @(posedge clk); #1;
    req2 = 1'b0;
    check("mo1_outstanding_limit", 32'(viol), 32'd0);
    check("mo1_rd_cnt", rd_cnt2, 32'd4);
    check("mo1_wr_cnt", wr_cnt2, 32'd0);

    // Pseudo-random stalls over 200 cycles of held request
    rd_base = rd_cnt;
    acc_m = 0; acc_d = 0; rv5 = 0; bad5 = 0; word = 0;
    q5.delete();
    @(posedge clk); #1;
    stall_en = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      exp_g = (mlfsr[1:0] != 2'b00);
      check("stall_gnt", 32'(gnt), 32'(exp_g));
      if (exp_g) begin
        acc_m++;
        q5.push_back(32'hA000_0000 + 32'(word));
      end
      if (gnt) acc_d++;
      if (rvalid) begin
        rv5++;
        if (q5.size() == 0 || rdata !== q5[0]) bad5++;
        if (q5.size() != 0) void'(q5.pop_front());
      end
      @(posedge clk); #1;
      if (gnt === 1'b0) begin end
      if (exp_g) begin
        word = (word + 1) % 8;
        addr = 32'(word * 4);
      end
      if (k == 199) req = 1'b0;
    end
    stall_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rvalid) begin
        rv5++;
        if (q5.size() == 0 || rdata !== q5[0]) bad5++;
        if (q5.size() != 0) void'(q5.pop_front());
      end
    end
    check("stall_accepts", 32'(acc_d), 32'(acc_m));
    check("stall_rd_cnt", rd_cnt - rd_base, 32'(acc_m));
    check("stall_resp_count", 32'(rv5), 32'(acc_m));
    check("stall_resp_order", 32'(bad5), 32'd0);

    // Reset with two reads in flight
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge clk); #1;
    addr = 32'h4;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    check("pre_rst_outstanding", 32'(outst), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_async_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid) viol++;
    end
    check("post_rst_no_rvalid", 32'(viol), 32'd0);
    check("post_rst_outstanding", 32'(outst), 32'd0);
    check("post_rst_rd_cnt", rd_cnt, 32'd0);
    check("post_rst_wr_cnt", wr_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
